pwr_ls_iso_sequencer: RTL

//  Power-up/down sequencer for one switchable low-voltage domain and its level-shifter boundary.

---
 rtl/pwr_ls_iso_sequencer_pkg.sv | 75 +++++++
 rtl/pwr_ls_iso_sequencer_if.sv | 37 +++
 rtl/pwr_ls_iso_sequencer_chk.sv | 27 ++
 rtl/pwr_ls_iso_sequencer_sync.sv | 28 ++
 rtl/pwr_ls_iso_sequencer.sv | 136 +++++++++++++
 5 files changed

// File: rtl/pwr_ls_iso_sequencer_pkg.sv
// Shared power-sequencer types: state encoding, registered output bundle and its decode.
// Used by every domain sequencer and by the PMU status mux.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    OFF    = 4'd0,
    PWR_UP = 4'd1,
    SETTLE = 4'd2,
    LS_ON  = 4'd3,
    ON     = 4'd4,
    ISO    = 4'd5,
    LS_OFF = 4'd6,
    PWR_DN = 4'd7,
    ERR    = 4'd8
  } pwr_seq_state_e;

  typedef struct packed {
    logic pwr_sw_en;
    logic iso_en;
    logic ls_en;
    logic domain_on;
    logic busy;
    logic timeout_err;
  } pwr_seq_out_t;

  // Safe boundary: switch off, clamps on, shifters off.
  localparam pwr_seq_out_t PWR_SEQ_SAFE_OUT = '{
    pwr_sw_en:   1'b0,
    iso_en:      1'b1,
    ls_en:       1'b0,
    domain_on:   1'b0,
    busy:        1'b0,
    timeout_err: 1'b0
  };

  function automatic pwr_seq_out_t pwr_seq_decode(input pwr_seq_state_e st);
    pwr_seq_out_t o;
    o = PWR_SEQ_SAFE_OUT;
    case (st)
      OFF: begin
        o = PWR_SEQ_SAFE_OUT;
      end
      PWR_UP, SETTLE: begin
        o.pwr_sw_en = 1'b1;
        o.busy      = 1'b1;
      end
      LS_ON, ISO: begin
        o.pwr_sw_en = 1'b1;
        o.ls_en     = 1'b1;
        o.busy      = 1'b1;
      end
      ON: begin
        o.pwr_sw_en = 1'b1;
        o.iso_en    = 1'b0;
        o.ls_en     = 1'b1;
        o.domain_on = 1'b1;
      end
      LS_OFF: begin
        o.pwr_sw_en = 1'b1;
        o.busy      = 1'b1;
      end
      PWR_DN: begin
        o.busy = 1'b1;
      end
      ERR: begin
        o.timeout_err = 1'b1;
      end
      default: begin
        o.timeout_err = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pwr_ls_iso_sequencer_if.sv
// Control/status bundle between the PMU and one low-voltage domain sequencer.
// master = PMU / power switch side, slave = the sequencer.
interface pwr_ls_iso_sequencer_if;
  logic pd_req_i;
  logic pwr_ack_i;
  logic err_clr_i;
  logic pwr_sw_en_o;
  logic iso_en_o;
  logic ls_en_o;
  logic domain_on_o;
  logic busy_o;
  logic timeout_err_o;

  modport master (
    output pd_req_i,
    output pwr_ack_i,
    output err_clr_i,
    input  pwr_sw_en_o,
    input  iso_en_o,
    input  ls_en_o,
    input  domain_on_o,
    input  busy_o,
    input  timeout_err_o
  );

  modport slave (
    input  pd_req_i,
    input  pwr_ack_i,
    input  err_clr_i,
    output pwr_sw_en_o,
    output iso_en_o,
    output ls_en_o,
    output domain_on_o,
    output busy_o,
    output timeout_err_o
  );
endinterface

// File: rtl/pwr_ls_iso_sequencer_chk.sv
// Ordering checks for the LV boundary controls of pwr_ls_iso_sequencer.
module pwr_ls_iso_sequencer_chk (
  input logic clk_high_voltage,
  input logic rst_n,
  input logic pwr_sw_en_o,
  input logic iso_en_o,
  input logic ls_en_o,
  input logic domain_on_o
);

  a_clamp_when_unpowered: assert property (@(posedge clk_high_voltage) disable iff (!rst_n)
    (!ls_en_o || !pwr_sw_en_o) |-> iso_en_o)
    else $error("boundary unclamped while shifters or switch are off");

  a_ls_needs_switch: assert property (@(posedge clk_high_voltage) disable iff (!rst_n)
    ls_en_o |-> pwr_sw_en_o)
    else $error("level shifters enabled without switch");

  a_iso_fall_into_on: assert property (@(posedge clk_high_voltage) disable iff (!rst_n)
    $fell(iso_en_o) |-> (domain_on_o && $past(ls_en_o)))
    else $error("clamp released outside LS_ON to ON");

  a_ls_fall_in_ls_off: assert property (@(posedge clk_high_voltage) disable iff (!rst_n)
    $fell(ls_en_o) |-> (pwr_sw_en_o && iso_en_o && !domain_on_o))
    else $error("level shifters dropped outside LS_OFF");

endmodule

// File: rtl/pwr_ls_iso_sequencer_sync.sv
// Two-flop synchronizer with configurable reset value, shared by the pwr blocks.
module pwr_sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability filter stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pwr_ls_iso_sequencer.sv
// Power-up/down sequencer for one switchable LV domain and its level-shifter boundary.
// Orders switch, isolation clamps and level-shifter enable; ack wait with timeout.
module pwr_ls_iso_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic                   clk_high_voltage,
  input  logic                   rst_n,
  pwr_ls_iso_sequencer_if.slave  bus
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // SETTLE is held for SETTLE_CYCLES full cycles after its entry edge, so the
  // boundary opens SETTLE_CYCLES+4 edges after an up request with ack already high.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  pwr_seq_state_e   state_r;
  pwr_seq_state_e   state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  pwr_seq_out_t     out_r;
  logic             ack_s;

  pwr_sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_ack_sync (
    .clk   (clk_high_voltage),
    .rst_n (rst_n),
    .d     (bus.pwr_ack_i),
    .q     (ack_s)
  );

  assign cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_ONE);

  // Next-state and counter selection; requests are only honoured in OFF/ON/ERR.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      OFF: begin
        if (!bus.pd_req_i) begin
          state_nxt_s = PWR_UP;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = OFF;
        end
      end
      PWR_UP: begin
        if (ack_s) begin
          state_nxt_s = SETTLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nxt_s = ERR;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_nxt_s = LS_ON;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      LS_ON: begin
        state_nxt_s = ON;
      end
      ON: begin
        if (bus.pd_req_i) begin
          state_nxt_s = ISO;
        end else begin
          state_nxt_s = ON;
        end
      end
      ISO: begin
        state_nxt_s = LS_OFF;
      end
      LS_OFF: begin
        state_nxt_s = PWR_DN;
        cnt_nxt_s   = CNT_ZERO;
      end
      PWR_DN: begin
        if (!ack_s) begin
          state_nxt_s = OFF;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nxt_s = ERR;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      ERR: begin
        if (bus.err_clr_i) begin
          state_nxt_s = OFF;
        end else begin
          state_nxt_s = ERR;
        end
      end
      default: begin
        // Corrupted encoding: park in ERR with the boundary clamped.
        state_nxt_s = ERR;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and output registers; reset clamps the boundary immediately.
  always_ff @(posedge clk_high_voltage or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= OFF;
      cnt_r   <= CNT_ZERO;
      out_r   <= PWR_SEQ_SAFE_OUT;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      out_r   <= pwr_seq_decode(state_nxt_s);
    end
  end

  assign bus.pwr_sw_en_o   = out_r.pwr_sw_en;
  assign bus.iso_en_o      = out_r.iso_en;
  assign bus.ls_en_o       = out_r.ls_en;
  assign bus.domain_on_o   = out_r.domain_on;
  assign bus.busy_o        = out_r.busy;
  assign bus.timeout_err_o = out_r.timeout_err;

endmodule
